serial_cfg_lut: RTL and testbench

Parametrised K-input lookup table with a serial configuration chain. Config bits shift into a staging register. A commit pulse copies them atomically into the active table, so the LUT output never shows a partially loaded truth table. A serial-out pin allows several LUTs to be daisy-chained on one config stream. This block is the generalised successor of the fixed 3-input, 8-bit shift-register LUT.

---
 rtl/lut_pkg.sv | 19 +
 rtl/cfg_shift_reg.sv | 68 ++++++
 rtl/serial_cfg_lut.sv | 98 +++++++++
 tb/tb_serial_cfg_lut.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/lut_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lut_pkg
// Description : Shared constants and configuration-state encoding for the
//               serial-configured LUT family.
// Revision    : 1.0 - initial release
// ============================================================================
package lut_pkg;

    localparam int LUT_K_MAX = 6;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        LOAD  = 2'd1,
        FULL  = 2'd2
    } cfg_state_t;

endpackage
`default_nettype wire

// File: rtl/cfg_shift_reg.sv
`default_nettype none
// ============================================================================
// Module      : cfg_shift_reg
// Description : DEPTH-bit serial staging register with saturating bit count.
// Revision    : 1.0 - initial release
// ============================================================================
module cfg_shift_reg
    import lut_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_enable,
    input  logic             i_din,
    input  logic             i_clear,
    output logic [DEPTH-1:0] o_stg,
    output logic             o_so,
    output logic             o_full
);

    localparam int              CW      = $clog2(DEPTH + 1);
    localparam logic [CW-1:0]   c_depth = CW'(DEPTH);
    localparam logic [CW-1:0]   c_one   = CW'(1);

    logic [DEPTH-1:0] r_stg;
    logic [CW-1:0]    r_cnt;
    logic [CW-1:0]    w_cnt_nxt;
    cfg_state_t       r_state;
    cfg_state_t       w_state_nxt;

    // A clear comes only from an accepted commit; a shift in the same cycle
    // counts as the first bit of the next stream.
    always_comb begin
        w_cnt_nxt   = r_cnt;
        w_state_nxt = LOAD;
        if (i_clear) begin
            w_cnt_nxt = i_enable ? c_one : '0;
        end else if (i_enable && (r_cnt != c_depth)) begin
            w_cnt_nxt = r_cnt + c_one;
        end
        if (w_cnt_nxt == '0) begin
            w_state_nxt = EMPTY;
        end else if (w_cnt_nxt == c_depth) begin
            w_state_nxt = FULL;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stg   <= '0;
            r_cnt   <= '0;
            r_state <= EMPTY;
        end else begin
            if (i_enable) begin
                r_stg <= {r_stg[DEPTH-2:0], i_din};
            end
            r_cnt   <= w_cnt_nxt;
            r_state <= w_state_nxt;
        end
    end

    assign o_stg  = r_stg;
    assign o_so   = r_stg[DEPTH-1];
    assign o_full = (r_state == FULL);

endmodule
`default_nettype wire

// File: rtl/serial_cfg_lut.sv
`default_nettype none
// ============================================================================
// Module      : serial_cfg_lut
// Description : K-input LUT loaded through a daisy-chainable serial stream,
//               with atomic commit from staging into the active table.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_cfg_lut
    import lut_pkg::*;
#(
    parameter int                INIT_K_DUMMY = 0,
    parameter int                K       = 3,
    parameter logic [2**K-1:0]   INIT    = '0,
    parameter bit                REG_OUT = 1'b0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          enable,
    input  logic          S,
    input  logic          commit,
    input  logic [K-1:0]  sel,
    output logic          Z,
    output logic          so,
    output logic          cfg_done,
    output logic          cfg_err,
    output logic          full
);

    localparam int DEPTH = 2**K;

    generate
        if ((K < 1) || (K > LUT_K_MAX) || (INIT_K_DUMMY != 0)) begin : g_bad_k
            $error("serial_cfg_lut: K out of range");
        end
    endgenerate

    logic [DEPTH-1:0] w_stg;
    logic             w_full;
    logic             w_accept;
    logic             w_reject;
    logic [DEPTH-1:0] r_act;
    logic             r_done;
    logic             r_err;

    assign w_accept = commit & w_full;
    assign w_reject = commit & ~w_full;

    cfg_shift_reg #(
        .DEPTH (DEPTH)
    ) u_cfg_shift_reg (
        .clk      (clk),
        .reset    (reset),
        .i_enable (enable),
        .i_din    (S),
        .i_clear  (w_accept),
        .o_stg    (w_stg),
        .o_so     (so),
        .o_full   (w_full)
    );

    // w_stg is the pre-shift staging value, so a commit coinciding with a
    // shift still captures the complete table.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_act  <= INIT;
            r_done <= 1'b0;
            r_err  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_act <= w_stg;
            end
            r_done <= w_accept;
            r_err  <= w_reject;
        end
    end

    generate
        if (REG_OUT) begin : g_reg_out
            logic r_z;
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_z <= 1'b0;
                end else begin
                    r_z <= r_act[sel];
                end
            end
            assign Z = r_z;
        end else begin : g_comb_out
            assign Z = r_act[sel];
        end
    endgenerate

    assign cfg_done = r_done;
    assign cfg_err  = r_err;
    assign full     = w_full;

endmodule
`default_nettype wire

// File: tb/tb_serial_cfg_lut.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_cfg_lut
// Description : Self-checking bench for serial_cfg_lut (K=3, both output modes).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_cfg_lut;

    localparam int         D      = 8;
    localparam logic [7:0] INIT_V = 8'hE8;

    logic       clk = 1'b0;
    logic       reset, enable, S, commit;
    logic [2:0] sel;
    logic       z0, so0, done0, err0, full0;
    logic       z1, so1, done1, err1, full1;

    always #5 clk = ~clk;

    serial_cfg_lut #(.K(3), .INIT(INIT_V), .REG_OUT(1'b0)) u_comb (
        .clk(clk), .reset(reset), .enable(enable), .S(S), .commit(commit),
        .sel(sel), .Z(z0), .so(so0), .cfg_done(done0), .cfg_err(err0), .full(full0)
    );

    serial_cfg_lut #(.K(3), .INIT(INIT_V), .REG_OUT(1'b1)) u_reg (
        .clk(clk), .reset(reset), .enable(enable), .S(S), .commit(commit),
        .sel(sel), .Z(z1), .so(so1), .cfg_done(done1), .cfg_err(err1), .full(full1)
    );

    // Reference model: history of shifted bits, bits counted since last load.
    bit         hist[$];
    int         since;
    logic [7:0] m_act;
    logic       m_done, m_err, m_zr;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [2:0] sel;
        logic       maj;
        logic       xr;
        logic       lo;
    } vec_t;
    vec_t tbl[8];

    function automatic logic [7:0] m_stg();
        logic [7:0] v = '0;
        for (int i = 0; i < D; i++)
            if (i < hist.size()) v[i] = hist[hist.size() - 1 - i];
        return v;
    endfunction

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all();
        logic [7:0] s;
        s = m_stg();
        chk("z_comb",  z0,    m_act[sel]);
        chk("z_reg",   z1,    m_zr);
        chk("so",      so0,   s[7]);
        chk("so_reg",  so1,   s[7]);
        chk("full",    full0, since >= D);
        chk("full_reg",full1, since >= D);
        chk("done",    done0, m_done);
        chk("done_reg",done1, m_done);
        chk("err",     err0,  m_err);
        chk("err_reg", err1,  m_err);
    endtask

    task automatic cyc(input logic r, input logic en, input logic s,
                       input logic cm, input logic [2:0] sl);
        logic acc;
        reset = r; enable = en; S = s; commit = cm; sel = sl;
        @(posedge clk);
        if (r) begin
            hist.delete();
            since  = 0;
            m_act  = INIT_V;
            m_done = 1'b0;
            m_err  = 1'b0;
            m_zr   = 1'b0;
        end else begin
            acc    = cm && (since >= D);
            m_zr   = m_act[sl];
            m_done = acc;
            m_err  = cm && !acc;
            if (acc) begin
                m_act = m_stg();
                since = en ? 1 : 0;
            end else if (en) begin
                since++;
            end
            if (en) begin
                hist.push_back(s);
                if (hist.size() > D) void'(hist.pop_front());
            end
        end
        #1;
        check_all();
    endtask

    task automatic shift_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) cyc(0, 1, b[i], 0, 3'd0);
    endtask

    task automatic sweep(input int which);
        logic e;
        for (int i = 0; i < 8; i++) begin
            cyc(0, 0, 0, 0, tbl[i].sel);
            e = (which == 0) ? tbl[i].maj : (which == 1) ? tbl[i].xr : tbl[i].lo;
            chk("tbl_z_comb", z0, e);
            chk("tbl_z_reg",  z1, e);
        end
    endtask

    initial begin
        logic [7:0] a5;
        logic [7:0] v96;
        logic [7:0] v0f;
        logic [7:0] sob;
        logic       b;
        a5  = 8'hA5;
        v96 = 8'h96;
        v0f = 8'h0F;
        sob = '0;
        // {sel, MAJ3 (E8), XOR3 (96), 0F}
        tbl[0] = '{3'd0, 1'b0, 1'b0, 1'b1};
        tbl[1] = '{3'd1, 1'b0, 1'b1, 1'b1};
        tbl[2] = '{3'd2, 1'b0, 1'b1, 1'b1};
        tbl[3] = '{3'd3, 1'b1, 1'b0, 1'b1};
        tbl[4] = '{3'd4, 1'b0, 1'b1, 1'b0};
        tbl[5] = '{3'd5, 1'b1, 1'b0, 1'b0};
        tbl[6] = '{3'd6, 1'b1, 1'b0, 1'b0};
        tbl[7] = '{3'd7, 1'b1, 1'b1, 1'b0};

        // Reset state and INIT sweep
        cyc(1, 0, 0, 0, 3'd0);
        cyc(1, 0, 0, 0, 3'd0);
        chk("rst_full", full0, 1'b0);
        chk("rst_so",   so0,   1'b0);
        sweep(0);

        // Full load of XOR3 and commit
        shift_byte(v96);
        chk("load_full", full0, 1'b1);
        cyc(0, 0, 0, 1, 3'd0);
        chk("commit_done", done0, 1'b1);
        chk("commit_err",  err0,  1'b0);
        cyc(0, 0, 0, 0, 3'd0);
        chk("done_one_cycle", done0, 1'b0);
        chk("full_dropped",   full0, 1'b0);
        sweep(1);

        // Partial load rejected, completion accepted
        cyc(1, 0, 0, 0, 3'd0);
        for (int i = 0; i < 5; i++) cyc(0, 1, 1'b1, 0, 3'd0);
        cyc(0, 0, 0, 1, 3'd0);
        chk("partial_err", err0, 1'b1);
        chk("partial_done", done0, 1'b0);
        sweep(0);
        for (int i = 0; i < 3; i++) cyc(0, 1, 1'b0, 0, 3'd0);
        cyc(0, 0, 0, 1, 3'd0);
        chk("complete_done", done0, 1'b1);

        // Commit and shift in the same edge
        shift_byte(a5);
        cyc(0, 1, 1'b1, 1, 3'd0);
        chk("simul_done", done0, 1'b1);
        chk("simul_full", full0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            cyc(0, 0, 0, 0, 3'(i));
            chk("simul_act", z0, a5[i]);
        end
        for (int i = 0; i < 6; i++) cyc(0, 1, 1'b0, 0, 3'd0);
        chk("simul_not_full", full0, 1'b0);
        cyc(0, 1, 1'b0, 0, 3'd0);
        chk("simul_refull", full0, 1'b1);
        cyc(0, 0, 0, 1, 3'd0);
        chk("simul_done2", done0, 1'b1);

        // Sixteen-bit stream: first byte emerges on so
        cyc(1, 0, 0, 0, 3'd0);
        for (int j = 0; j < 16; j++) begin
            b = (j < 8) ? v96[7 - j] : v0f[15 - j];
            cyc(0, 1, b, 0, 3'd0);
            if (j >= 7 && j <= 14) sob = {sob[6:0], so0};
        end
        checks++;
        if (sob !== 8'h96) begin
            errors++;
            $display("FAIL so_stream: got %h expected 96", sob);
        end
        cyc(0, 0, 0, 1, 3'd0);
        chk("cascade_done", done0, 1'b1);
        sweep(2);

        // Reset mid-load with registered output
        for (int i = 0; i < 4; i++) cyc(0, 1, 1'b1, 0, 3'd3);
        cyc(1, 0, 0, 0, 3'd3);
        chk("rst_zreg_zero", z1, 1'b0);
        cyc(0, 0, 0, 0, 3'd3);
        chk("rst_zreg_init", z1, INIT_V[3]);
        chk("rst_full_mid",  full0, 1'b0);
        cyc(0, 0, 0, 1, 3'd3);
        chk("rst_commit_err", err0, 1'b1);

        // Randomised traffic against the model
        for (int n = 0; n < 3000; n++) begin
            cyc(($urandom_range(0, 199) == 0),
                ($urandom_range(0, 3) != 0),
                1'($urandom),
                ($urandom_range(0, 11) == 0),
                3'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
